// File: rtl/mouse_pos_tracker_if.sv
// Byte-stream input from the PS/2 receiver and pointer outputs to the game controller.
// The tracker takes the slave side; whatever feeds bytes and consumes the pointer takes master.
interface mouse_pos_tracker_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        mouse_left;
  logic        mouse_right;
  logic        mouse_left_press;
  logic        packet_valid;

  modport master (
    output rx_data, rx_valid,
    input  xpos, ypos, mouse_left, mouse_right, mouse_left_press, packet_valid
  );

  modport slave (
    input  rx_data, rx_valid,
    output xpos, ypos, mouse_left, mouse_right, mouse_left_press, packet_valid
  );
endinterface

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 movement packets and integrates them into a clamped
// absolute pointer position on a 1024x768 screen, plus button levels and a left-press pulse.
module mouse_pos_tracker #(
  parameter int XMAX    = 1023,
  parameter int YMAX    = 767,
  parameter int X_INIT  = 512,
  parameter int Y_INIT  = 384,
  parameter int TIMEOUT = 65000
) (
  input  logic               clk,
  input  logic               rst_n,
  mouse_pos_tracker_if.slave bus_if
);

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic signed [12:0] XMAX13 = 13'(XMAX);
  localparam logic signed [12:0] YMAX13 = 13'(YMAX);

  typedef enum logic [1:0] {B0, B1, B2, APPLY} state_e;

  state_e      state_q, state_d;
  logic [5:0]  flags_q, flags_d;   // {y_ovf, x_ovf, y_sign, x_sign, right, left}
  logic [7:0]  dx_q, dx_d;
  logic [7:0]  dy_q, dy_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic        left_q, left_d;
  logic        right_q, right_d;
  logic        press_q, press_d;
  logic        pv_q, pv_d;

  logic signed [12:0] dx13, dy13, nx, ny;
  logic               timeout;

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    gap_d   = '0;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    left_d  = left_q;
    right_d = right_q;
    press_d = 1'b0;
    pv_d    = 1'b0;

    dx13 = {{4{flags_q[2]}}, flags_q[2], dx_q};
    dy13 = {{4{flags_q[3]}}, flags_q[3], dy_q};
    nx   = $signed({1'b0, xpos_q}) + dx13;
    ny   = $signed({1'b0, ypos_q}) - dy13;   // PS/2 Y grows upward, screen Y grows downward

    timeout = ((state_q == B1) || (state_q == B2)) && (gap_q == GW'(TIMEOUT));

    if (state_q == APPLY) begin
      if (!flags_q[4]) begin
        if (nx[12])           xpos_d = '0;
        else if (nx > XMAX13) xpos_d = XMAX13[11:0];
        else                  xpos_d = nx[11:0];
      end
      if (!flags_q[5]) begin
        if (ny[12])           ypos_d = '0;
        else if (ny > YMAX13) ypos_d = YMAX13[11:0];
        else                  ypos_d = ny[11:0];
      end
      left_d  = flags_q[0];
      right_d = flags_q[1];
      press_d = flags_q[0] & ~left_q;
      pv_d    = 1'b1;
    end

    // APPLY and an expired gap both fall back to byte-0 rules for a byte on this edge.
    if ((state_q == B0) || (state_q == APPLY) || timeout) begin
      state_d = B0;
      if (bus_if.rx_valid && bus_if.rx_data[3]) begin
        flags_d = {bus_if.rx_data[7:4], bus_if.rx_data[1:0]};
        state_d = B1;
      end
    end else if (state_q == B1) begin
      if (bus_if.rx_valid) begin
        dx_d    = bus_if.rx_data;
        state_d = B2;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end else begin
      if (bus_if.rx_valid) begin
        dy_d    = bus_if.rx_data;
        state_d = APPLY;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= B0;
      flags_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      gap_q   <= '0;
      xpos_q  <= 12'(X_INIT);
      ypos_q  <= 12'(Y_INIT);
      left_q  <= 1'b0;
      right_q <= 1'b0;
      press_q <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      gap_q   <= gap_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      left_q  <= left_d;
      right_q <= right_d;
      press_q <= press_d;
      pv_q    <= pv_d;
    end
  end

  assign bus_if.xpos             = xpos_q;
  assign bus_if.ypos             = ypos_q;
  assign bus_if.mouse_left       = left_q;
  assign bus_if.mouse_right      = right_q;
  assign bus_if.mouse_left_press = press_q;
  assign bus_if.packet_valid     = pv_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Bench for mouse_pos_tracker: directed scenarios plus random packet streams, all
// outputs compared every cycle against a packet-level reference model.
module tb_mouse_pos_tracker;

  localparam int TO = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mouse_pos_tracker_if bus ();

  mouse_pos_tracker #(
    .XMAX(1023), .YMAX(767), .X_INIT(512), .Y_INIT(384), .TIMEOUT(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pv_seen    = 0;
  int press_seen = 0;

  // Reference model state
  int exp_x, exp_y;
  bit exp_left, exp_right, exp_press, exp_pv;
  bit pend;
  int pend_x, pend_y;
  bit pend_left, pend_right, pend_press;
  logic [7:0] pkt[$];
  int cyc, last_t;

  task automatic model_reset();
    exp_x = 512; exp_y = 384;
    exp_left = 0; exp_right = 0; exp_press = 0; exp_pv = 0;
    pend = 0; pkt.delete(); cyc = 0; last_t = 0;
  endtask

  task automatic model_step();
    logic [7:0] f;
    int d, n;
    exp_pv = 0;
    exp_press = 0;
    if (pend) begin
      exp_x = pend_x; exp_y = pend_y;
      exp_left = pend_left; exp_right = pend_right;
      exp_press = pend_press; exp_pv = 1; pend = 0;
    end
    if (pkt.size() > 0 && (cyc - last_t) > TO) pkt.delete();
    if (bus.rx_valid) begin
      if (pkt.size() > 0 || bus.rx_data[3]) begin
        pkt.push_back(bus.rx_data);
        last_t = cyc;
      end
      if (pkt.size() == 3) begin
        f = pkt[0];
        pend_x = exp_x;
        pend_y = exp_y;
        if (!f[6]) begin
          d = f[4] ? int'(pkt[1]) - 256 : int'(pkt[1]);
          n = exp_x + d;
          pend_x = (n < 0) ? 0 : (n > 1023) ? 1023 : n;
        end
        if (!f[7]) begin
          d = f[5] ? int'(pkt[2]) - 256 : int'(pkt[2]);
          n = exp_y - d;
          pend_y = (n < 0) ? 0 : (n > 767) ? 767 : n;
        end
        pend_left  = f[0];
        pend_right = f[1];
        pend_press = f[0] & ~exp_left;
        pend = 1;
        pkt.delete();
      end
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        n_checks++;
        if (bus.xpos !== 12'(exp_x) || bus.ypos !== 12'(exp_y) ||
            bus.mouse_left !== exp_left || bus.mouse_right !== exp_right ||
            bus.mouse_left_press !== exp_press || bus.packet_valid !== exp_pv) begin
          n_fail++;
          $display("FAIL cycle_cmp t=%0t got x=%0d y=%0d l=%b r=%b p=%b v=%b want x=%0d y=%0d l=%b r=%b p=%b v=%b",
                   $time, bus.xpos, bus.ypos, bus.mouse_left, bus.mouse_right,
                   bus.mouse_left_press, bus.packet_valid,
                   exp_x, exp_y, exp_left, exp_right, exp_press, exp_pv);
        end
        if (bus.packet_valid === 1'b1) pv_seen++;
        if (bus.mouse_left_press === 1'b1) press_seen++;
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, req);
    end
    else $display("ok   %s = %0d", name, act);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0); send_byte(b1); send_byte(b2);
    idle(3);
  endtask

  task automatic send_move(input logic [7:0] btn, input int dx, input int dy);
    logic [8:0] dx9, dy9;
    logic [7:0] f;
    dx9 = 9'(dx);
    dy9 = 9'(dy);
    f = btn | 8'h08;
    f[4] = dx9[8];
    f[5] = dy9[8];
    send3(f, dx9[7:0], dy9[7:0]);
  endtask

  task automatic move_to(input int x, input int y);
    int rx, ry, sx, sy;
    repeat (5) send_move(8'h00, -255, 255);
    rx = x; ry = y;
    while (rx > 0 || ry > 0) begin
      sx = (rx > 255) ? 255 : rx;
      sy = (ry > 255) ? 255 : ry;
      send_move(8'h00, sx, -sy);
      rx -= sx; ry -= sy;
    end
  endtask

  initial begin
    int pv0, g;
    logic [7:0] b;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    repeat (3) @(negedge clk);
    check_lit("reset_xpos", int'(bus.xpos), 512);
    check_lit("reset_ypos", int'(bus.ypos), 384);
    check_lit("reset_flags", int'({bus.mouse_left, bus.mouse_right, bus.mouse_left_press, bus.packet_valid}), 0);
    rst_n = 1'b1;

    // First packet and exact latency: outputs change one edge after byte 2's edge
    send_byte(8'h08); send_byte(8'h0A); send_byte(8'h05);
    idle(1);
    check_lit("lat_not_yet_x", int'(bus.xpos), 512);
    idle(1);
    check_lit("first_xpos", int'(bus.xpos), 522);
    check_lit("first_ypos", int'(bus.ypos), 379);
    check_lit("first_pv", int'(bus.packet_valid), 1);
    check_lit("model_first_x", exp_x, 522);
    idle(2);

    move_to(10, 200);
    send3(8'h18, 8'hEC, 8'h00);
    check_lit("x_clamp_low", int'(bus.xpos), 0);
    move_to(1020, 200);
    send3(8'h08, 8'h64, 8'h00);
    check_lit("x_clamp_high", int'(bus.xpos), 1023);
    check_lit("model_x_clamp_high", exp_x, 1023);

    move_to(300, 760);
    send3(8'h28, 8'h00, 8'hF6);
    check_lit("y_clamp_high", int'(bus.ypos), 767);
    pv0 = pv_seen;
    send3(8'h88, 8'h00, 8'h50);
    check_lit("y_ovf_unchanged", int'(bus.ypos), 767);
    check_lit("y_ovf_pv_once", pv_seen - pv0, 1);

    press_seen = 0;
    send3(8'h09, 8'h00, 8'h00);
    check_lit("click1_left", int'(bus.mouse_left), 1);
    send3(8'h09, 8'h00, 8'h00);
    check_lit("click2_left", int'(bus.mouse_left), 1);
    send3(8'h08, 8'h00, 8'h00);
    check_lit("click3_left", int'(bus.mouse_left), 0);
    check_lit("press_pulses", press_seen, 1);

    move_to(100, 200);
    pv0 = pv_seen;
    send_byte(8'h00); idle(3);
    check_lit("junk_no_pv", pv_seen - pv0, 0);
    send_byte(8'h08); idle(TO);
    send3(8'h08, 8'h01, 8'h01);
    check_lit("resync_x", int'(bus.xpos), 101);
    check_lit("resync_y", int'(bus.ypos), 199);
    send_byte(8'h08); idle(TO - 1);
    send_byte(8'h01); send_byte(8'h01); idle(3);
    check_lit("gap_limit_x", int'(bus.xpos), 102);
    check_lit("gap_limit_y", int'(bus.ypos), 198);
    send_byte(8'h08); idle(TO);
    send3(8'h09, 8'h02, 8'h03);
    check_lit("timeout_edge_x", int'(bus.xpos), 104);
    check_lit("timeout_edge_y", int'(bus.ypos), 195);
    check_lit("model_timeout_y", exp_y, 195);

    // Random packets with junk bytes, variable gaps and overlapping APPLY
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = 8'($urandom);
        b[3] = 1'b0;
        send_byte(b);
        idle($urandom_range(1, 2));
      end else begin
        b = 8'($urandom);
        b[3] = 1'b1;
        send_byte(b);
        g = $urandom_range(0, 2); if (g > 0) idle(g);
        send_byte(8'($urandom));
        g = $urandom_range(0, 2); if (g > 0) idle(g);
        send_byte(8'($urandom));
        g = $urandom_range(0, 3); if (g > 0) idle(g);
      end
    end
    idle(3);

    // Asynchronous reset mid-packet, then a stray continuation byte and a clean packet
    send_byte(8'h08); send_byte(8'h10);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_lit("areset_xpos", int'(bus.xpos), 512);
    check_lit("areset_ypos", int'(bus.ypos), 384);
    check_lit("areset_flags", int'({bus.mouse_left, bus.mouse_right, bus.mouse_left_press, bus.packet_valid}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h05); idle(2);
    send3(8'h08, 8'h03, 8'h02);
    check_lit("post_reset_x", int'(bus.xpos), 515);
    check_lit("post_reset_y", int'(bus.ypos), 382);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
